pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline. It drives the write-enable, flush and hold controls of the PC and of the IF/ID, ID/EX and EX/MEM/MEM/WB pipeline registers, using three inputs:
- load-use hazards (load in EX),
- taken-branch and jump redirects,
- the data-memory ready handshake in MEM.

A wait-state FSM with a timeout supervises memory stalls. Saturating counters record stall and flush activity for debug.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM wait cycles before fault (>=2)
CNT_W, 16, width of stall/flush performance counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
ID_Rs  in  5  rs field of instruction in ID
ID_Rt  in  5  rt field of instruction in ID
ID_UseRs  in  1  ID instruction reads rs
ID_UseRt  in  1  ID instruction reads rt
ID_Jump  in  1  jump decoded in ID (target available in ID)
EX_MemRead  in  1  MemRead output of ID/EX register
EX_Rt  in  5  Rt output of ID/EX register
EX_BranchTaken  in  1  branch resolved taken in EX
MEM_Req  in  1  MEM stage issuing data-memory access
MEM_Ready  in  1  data memory completes access this cycle
PC_Write  out  1  PC update enable
IFID_Write  out  1  IF/ID register update enable
IFID_Flush  out  1  IF/ID insert bubble
IDEX_Flush  out  1  ID/EX Flush (kills MemWrite/MemRead/RegWrite)
Pipe_Hold  out  1  freeze ID/EX, EX/MEM, MEM/WB
Mem_Err  out  1  sticky memory-timeout fault
Stall_Cnt  out  CNT_W  stall cycles, saturating
Flush_Cnt  out  CNT_W  redirect events, saturating

Behaviour:
- FSM states: RUN, MEM_WAIT, FAULT. State and counters are registered; control outputs are combinational from state and current inputs.
- Reset low (async, any time, including mid-wait): state=RUN, wait counter=0, Mem_Err=0, Stall_Cnt=0, Flush_Cnt=0. While reset is low: PC_Write=0, IFID_Write=0, IFID_Flush=0, IDEX_Flush=0, Pipe_Hold=0.
- memwait = MEM_Req & ~MEM_Ready.
- loaduse = EX_MemRead & (EX_Rt!=0) & ((ID_UseRs & ID_Rs==EX_Rt) | (ID_UseRt & ID_Rt==EX_Rt)).
- Priority in RUN, highest first: memwait > EX_BranchTaken > loaduse > ID_Jump > none.
- memwait:
  - PC_Write=0, IFID_Write=0, Pipe_Hold=1, no flushes.
  - next state MEM_WAIT, wait counter=1.
  - Branch/load-use/jump are not acted on this cycle; they re-evaluate when the hold releases, since the frozen registers keep them stable.
- EX_BranchTaken:
  - PC_Write=1, IFID_Write=1, IFID_Flush=1, IDEX_Flush=1.
  - Flush_Cnt+1.
  - Supersedes a simultaneous loaduse or ID_Jump (both are on the wrong path).
- loaduse:
  - PC_Write=0, IFID_Write=0, IDEX_Flush=1 (bubble), exactly one cycle per load; the load advancing to MEM clears the condition.
  - Stall_Cnt+1.
- ID_Jump:
  - PC_Write=1, IFID_Write=1, IFID_Flush=1, IDEX_Flush=0.
  - Flush_Cnt+1.
- none: PC_Write=1, IFID_Write=1, all flush/hold=0.
- MEM_WAIT:
  - Outputs as for memwait; Stall_Cnt+1 each cycle.
  - MEM_Ready=1: the hold releases in the same cycle (Pipe_Hold=0), and that cycle's outputs follow the RUN priority rules excluding memwait. Next state RUN.
  - Else, wait counter+1. If the counter reaches MEM_TIMEOUT without MEM_Ready, next state is FAULT.
  - The first memwait cycle counts in the Stall_Cnt total.
- FAULT: Mem_Err=1, PC_Write=0, IFID_Write=0, Pipe_Hold=1, flushes=0. Exit only via reset.
- Counters saturate at all-ones; no wrap.
- Rt/Rs == 0 never causes a load-use stall.

Test Plan:
- Reset low mid MEM_WAIT: state RUN; Stall_Cnt=0, Mem_Err=0; PC_Write=0 while low and 1 after release with no hazards.
- lw writes $5 in EX (EX_MemRead=1, EX_Rt=5); ID add with ID_Rs=5, ID_UseRs=1:
  - one cycle of PC_Write=0, IFID_Write=0, IDEX_Flush=1, Stall_Cnt=1;
  - next cycle EX_MemRead=0 gives normal flow.
  - Repeat with EX_Rt=0: no stall.
- EX_BranchTaken=1 with a simultaneous loaduse and ID_Jump: IFID_Flush=1, IDEX_Flush=1, PC_Write=1, Flush_Cnt+1, Stall_Cnt unchanged.
- MEM_Req=1, MEM_Ready=0 for 3 cycles, then 1:
  - Pipe_Hold=1 for 3 cycles, 0 on the 4th;
  - Stall_Cnt=3; state returns to RUN.
- MEM_Req=1, MEM_Ready held 0 (MEM_TIMEOUT=4): FAULT after 4 wait cycles; Mem_Err=1 stays set until reset.
- Force Stall_Cnt near max (CNT_W=4, 16+ stalls): holds at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard controller pipeline-side signal bundle
//
// Groups the hazard-detection inputs and the pipeline control outputs of
// pipe_hazard_ctrl.
//   master : pipeline side, drives ID/EX/MEM status, observes controls
//   slave  : controller side, observes status, drives controls
//   ID_Rs/ID_Rt/ID_UseRs/ID_UseRt/ID_Jump : decode-stage operand and jump info
//   EX_MemRead/EX_Rt/EX_BranchTaken        : execute-stage load and branch info
//   MEM_Req/MEM_Ready                      : data-memory handshake
//   PC_Write/IFID_Write/IFID_Flush/IDEX_Flush/Pipe_Hold : pipeline controls
//   Mem_Err/Stall_Cnt/Flush_Cnt            : fault flag and debug counters
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ID_Rs;
  logic [4:0]       ID_Rt;
  logic             ID_UseRs;
  logic             ID_UseRt;
  logic             ID_Jump;
  logic             EX_MemRead;
  logic [4:0]       EX_Rt;
  logic             EX_BranchTaken;
  logic             MEM_Req;
  logic             MEM_Ready;
  logic             PC_Write;
  logic             IFID_Write;
  logic             IFID_Flush;
  logic             IDEX_Flush;
  logic             Pipe_Hold;
  logic             Mem_Err;
  logic [CNT_W-1:0] Stall_Cnt;
  logic [CNT_W-1:0] Flush_Cnt;

  modport master (
    output ID_Rs, ID_Rt, ID_UseRs, ID_UseRt, ID_Jump,
    output EX_MemRead, EX_Rt, EX_BranchTaken, MEM_Req, MEM_Ready,
    input  PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, Pipe_Hold,
    input  Mem_Err, Stall_Cnt, Flush_Cnt
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UseRs, ID_UseRt, ID_Jump,
    input  EX_MemRead, EX_Rt, EX_BranchTaken, MEM_Req, MEM_Ready,
    output PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, Pipe_Hold,
    output Mem_Err, Stall_Cnt, Flush_Cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline hazard and memory-wait controller
//
// Resolves load-use stalls, branch/jump redirects and data-memory wait states
// into PC / pipeline-register enable, flush and hold controls. A wait-state
// FSM (RUN, MEM_WAIT, FAULT) supervises memory stalls with a timeout and
// raises a sticky Mem_Err. Stall and redirect activity is counted with
// saturating counters.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   hz    : pipe_hazard_ctrl_if slave port (hazard inputs, control outputs)
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] TIMEOUT_W = WW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WW-1:0]    wait_cnt, wait_cnt_n;
  logic             mem_err, mem_err_n;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  logic memwait, loaduse;

  // Controls chosen by the RUN priority rules (memwait excluded)
  logic run_pc_write, run_ifid_write, run_ifid_flush, run_idex_flush;
  logic run_stall, run_flush;

  logic pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold;
  logic stall_inc, flush_inc, use_run;

  assign memwait = hz.MEM_Req & ~hz.MEM_Ready;

  // Register 0 is hardwired, so a load targeting it never creates a hazard
  assign loaduse = hz.EX_MemRead && (hz.EX_Rt != 5'd0) &&
                   ((hz.ID_UseRs && (hz.ID_Rs == hz.EX_Rt)) ||
                    (hz.ID_UseRt && (hz.ID_Rt == hz.EX_Rt)));

  // A taken branch wins over load-use and jump: both are on the wrong path
  always_comb begin
    run_pc_write   = 1'b1;
    run_ifid_write = 1'b1;
    run_ifid_flush = 1'b0;
    run_idex_flush = 1'b0;
    run_stall      = 1'b0;
    run_flush      = 1'b0;
    if (hz.EX_BranchTaken) begin
      run_ifid_flush = 1'b1;
      run_idex_flush = 1'b1;
      run_flush      = 1'b1;
    end else if (loaduse) begin
      run_pc_write   = 1'b0;
      run_ifid_write = 1'b0;
      run_idex_flush = 1'b1;
      run_stall      = 1'b1;
    end else if (hz.ID_Jump) begin
      run_ifid_flush = 1'b1;
      run_flush      = 1'b1;
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pipe_hold  = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    use_run    = 1'b0;
    state_n    = state;
    wait_cnt_n = wait_cnt;
    mem_err_n  = mem_err;

    case (state)
      RUN: begin
        if (memwait) begin
          pipe_hold  = 1'b1;
          stall_inc  = 1'b1;
          state_n    = MEM_WAIT;
          wait_cnt_n = WW'(1);
        end else begin
          use_run = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (hz.MEM_Ready) begin
          // Hold releases this cycle; the frozen hazards are acted on now
          use_run    = 1'b1;
          state_n    = RUN;
          wait_cnt_n = '0;
        end else begin
          pipe_hold  = 1'b1;
          stall_inc  = 1'b1;
          wait_cnt_n = wait_cnt + WW'(1);
          if (wait_cnt_n == TIMEOUT_W) begin
            state_n   = FAULT;
            mem_err_n = 1'b1;
          end
        end
      end
      FAULT: begin
        pipe_hold = 1'b1;
      end
      default: begin
        state_n = RUN;
      end
    endcase

    if (use_run) begin
      pc_write   = run_pc_write;
      ifid_write = run_ifid_write;
      ifid_flush = run_ifid_flush;
      idex_flush = run_idex_flush;
      stall_inc  = run_stall;
      flush_inc  = run_flush;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      mem_err  <= mem_err_n;
      if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush_inc && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  // Controls are forced inactive for as long as reset is held low
  assign hz.PC_Write   = reset & pc_write;
  assign hz.IFID_Write = reset & ifid_write;
  assign hz.IFID_Flush = reset & ifid_flush;
  assign hz.IDEX_Flush = reset & idex_flush;
  assign hz.Pipe_Hold  = reset & pipe_hold;
  assign hz.Mem_Err    = mem_err;
  assign hz.Stall_Cnt  = stall_cnt;
  assign hz.Flush_Cnt  = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int TO   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) hz ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  // {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, Pipe_Hold}
  logic [4:0] ctl;
  assign ctl = {hz.PC_Write, hz.IFID_Write, hz.IFID_Flush, hz.IDEX_Flush, hz.Pipe_Hold};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic jmp, input logic mr,
                       input logic [4:0] ert, input logic br, input logic req,
                       input logic rdy);
    hz.ID_Rs = rs; hz.ID_Rt = rt; hz.ID_UseRs = urs; hz.ID_UseRt = urt;
    hz.ID_Jump = jmp; hz.EX_MemRead = mr; hz.EX_Rt = ert;
    hz.EX_BranchTaken = br; hz.MEM_Req = req; hz.MEM_Ready = rdy;
  endtask

  // Reference model: how long the current memory access has been waiting,
  // whether the controller gave up, and plain integer activity totals.
  bit m_fault, m_err;
  int m_wait, m_stall, m_flush;

  task automatic model_reset();
    m_fault = 0; m_err = 0; m_wait = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model_step(output logic [4:0] exp);
    bit mw, lu;
    mw = hz.MEM_Req && !hz.MEM_Ready;
    lu = hz.EX_MemRead && (hz.EX_Rt != 0) &&
         ((hz.ID_UseRs && hz.ID_Rs == hz.EX_Rt) || (hz.ID_UseRt && hz.ID_Rt == hz.EX_Rt));
    if (m_fault) begin
      exp = 5'b00001;
    end else if ((m_wait == 0 && mw) || (m_wait > 0 && !hz.MEM_Ready)) begin
      exp = 5'b00001;
      if (m_stall < CMAX) m_stall++;
      m_wait++;
      if (m_wait >= TO) begin
        m_fault = 1;
        m_err = 1;
      end
    end else begin
      m_wait = 0;
      if (hz.EX_BranchTaken) begin
        exp = 5'b11110;
        if (m_flush < CMAX) m_flush++;
      end else if (lu) begin
        exp = 5'b00010;
        if (m_stall < CMAX) m_stall++;
      end else if (hz.ID_Jump) begin
        exp = 5'b11100;
        if (m_flush < CMAX) m_flush++;
      end else begin
        exp = 5'b11000;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("reset_ctl", 16'(ctl), 16'h0);
    chk("reset_stall", 16'(hz.Stall_Cnt), 16'h0);
    chk("reset_flush", 16'(hz.Flush_Cnt), 16'h0);
    chk("reset_err", 16'(hz.Mem_Err), 16'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [4:0] rs, rt;
    logic       urs, urt, jmp, mr;
    logic [4:0] ert;
    logic       br, req, rdy;
    logic [4:0] ctl;
    int         st, fl;
  } vec_t;

  vec_t vt[17];

  initial begin
    logic [4:0] exp;

    //         rs rt urs urt jmp mr ert br req rdy  ctl       st fl
    vt[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0, 0};
    vt[1]  = '{5, 0, 1, 0, 0, 1, 5, 0, 0, 0, 5'b00010, 0, 0};
    vt[2]  = '{5, 0, 1, 0, 0, 0, 5, 0, 0, 0, 5'b11000, 1, 0};
    vt[3]  = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 5'b11000, 1, 0};
    vt[4]  = '{0, 7, 0, 1, 0, 1, 7, 0, 0, 0, 5'b00010, 1, 0};
    vt[5]  = '{0, 7, 0, 0, 0, 1, 7, 0, 0, 0, 5'b11000, 2, 0};
    vt[6]  = '{5, 0, 1, 0, 1, 1, 5, 1, 0, 0, 5'b11110, 2, 0};
    vt[7]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 5'b11100, 2, 1};
    vt[8]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5'b00001, 2, 2};
    vt[9]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5'b00001, 3, 2};
    vt[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5'b00001, 4, 2};
    vt[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b11000, 5, 2};
    vt[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b11000, 5, 2};
    vt[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 5, 2};
    vt[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00001, 5, 2};
    vt[15] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 5'b11110, 6, 2};
    vt[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 6, 3};

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();

    // Directed vectors: load-use, $0 immunity, branch priority, memory wait
    for (int i = 0; i < 17; i++) begin
      @(posedge clk);
      #1 drive(vt[i].rs, vt[i].rt, vt[i].urs, vt[i].urt, vt[i].jmp, vt[i].mr,
               vt[i].ert, vt[i].br, vt[i].req, vt[i].rdy);
      #3;
      chk($sformatf("vec%0d_ctl", i), 16'(ctl), 16'(vt[i].ctl));
      chk($sformatf("vec%0d_stall", i), 16'(hz.Stall_Cnt), 16'(vt[i].st));
      chk($sformatf("vec%0d_flush", i), 16'(hz.Flush_Cnt), 16'(vt[i].fl));
      chk($sformatf("vec%0d_err", i), 16'(hz.Mem_Err), 16'h0);
    end

    // Timeout: four unanswered wait cycles land in a sticky fault
    do_reset();
    for (int k = 0; k < TO; k++) begin
      @(posedge clk);
      #1 drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      #3;
      chk($sformatf("to_hold%0d", k), 16'(hz.Pipe_Hold), 16'h1);
      chk($sformatf("to_err%0d", k), 16'(hz.Mem_Err), 16'h0);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      #3;
      chk($sformatf("fault_err%0d", k), 16'(hz.Mem_Err), 16'h1);
      chk($sformatf("fault_ctl%0d", k), 16'(ctl), 16'b00001);
    end
    chk("fault_stall", 16'(hz.Stall_Cnt), 16'(TO));

    // Asynchronous reset in the middle of a memory wait
    do_reset();
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1 drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midwait_rst_pc", 16'(hz.PC_Write), 16'h0);
    chk("midwait_rst_stall", 16'(hz.Stall_Cnt), 16'h0);
    chk("midwait_rst_err", 16'(hz.Mem_Err), 16'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("midwait_post_ctl", 16'(ctl), 16'b11000);
    model_reset();

    // Stall counter saturation
    do_reset();
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1 drive(3, 0, 1, 0, 0, 1, 3, 0, 0, 0);
    end
    @(posedge clk);
    #1 drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("sat_stall", 16'(hz.Stall_Cnt), 16'(CMAX));

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 75 == 74) do_reset();
      @(posedge clk);
      #1 drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
               1'($urandom), 5'($urandom_range(0, 3)),
               ($urandom_range(0, 4) == 0), 1'($urandom),
               ($urandom_range(0, 2) != 0));
      #3;
      chk($sformatf("rnd%0d_stall", i), 16'(hz.Stall_Cnt), 16'(m_stall));
      chk($sformatf("rnd%0d_flush", i), 16'(hz.Flush_Cnt), 16'(m_flush));
      chk($sformatf("rnd%0d_err", i), 16'(hz.Mem_Err), 16'(m_err));
      model_step(exp);
      chk($sformatf("rnd%0d_ctl", i), 16'(ctl), 16'(exp));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
